// File: rtl/serial_word_unloader.sv
// Parallel-in, serial-out word unloader with ready/valid on both sides.
// Define SERIAL_UNLOADER_PARITY_EN to append an even-parity beat to each frame.
module serial_word_unloader #(
    parameter int WORD_LENGTH = 16,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Load_Valid,
    output logic                   Load_Ready,
    input  logic [WORD_LENGTH-1:0] Data_Input,
    output logic                   Serial_Output,
    output logic                   Serial_Valid,
    input  logic                   Serial_Ready,
    output logic                   Serial_Last,
    output logic                   Done
);

    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_PARITY
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_bit;
    logic                   at_last;

    assign out_bit = MSB_FIRST ? shreg_q[WORD_LENGTH-1] : shreg_q[0];
    assign at_last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_UNLOADER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (state_q == ST_IDLE && Load_Valid) begin
            parity_q <= ^Data_Input;
        end
    end
`endif

    // Outputs depend on registered state only; inputs steer next state.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        Load_Ready    = 1'b0;
        Serial_Valid  = 1'b0;
        Serial_Output = 1'b0;
        Serial_Last   = 1'b0;
        Done          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                Load_Ready = 1'b1;
                if (Load_Valid) begin
                    shreg_d = Data_Input;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                Serial_Valid  = 1'b1;
                Serial_Output = out_bit;
`ifndef SERIAL_UNLOADER_PARITY_EN
                Serial_Last   = at_last;
`endif
                if (Serial_Ready) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + 1'b1;
                    if (at_last) begin
`ifdef SERIAL_UNLOADER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef SERIAL_UNLOADER_PARITY_EN
            ST_PARITY: begin
                Serial_Valid  = 1'b1;
                Serial_Output = parity_q;
                Serial_Last   = 1'b1;
                if (Serial_Ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                Done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_unloader.sv
// Self-checking bench for serial_word_unloader: LSB-first and MSB-first
// instances share stimulus and are checked against a beat-queue model.
module tb_serial_word_unloader;

    localparam int W = 16;
`ifdef SERIAL_UNLOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = W + int'(PAR);

    logic         clk;
    logic         rst_n;
    logic         Load_Valid;
    logic [W-1:0] Data_Input;
    logic         Serial_Ready;
    logic         lr0, so0, sv0, sl0, dn0;
    logic         lr1, so1, sv1, sl1, dn1;

    serial_word_unloader #(.WORD_LENGTH(W), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(rst_n),
        .Load_Valid(Load_Valid), .Load_Ready(lr0),
        .Data_Input(Data_Input),
        .Serial_Output(so0), .Serial_Valid(sv0),
        .Serial_Ready(Serial_Ready), .Serial_Last(sl0),
        .Done(dn0)
    );

    serial_word_unloader #(.WORD_LENGTH(W), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(rst_n),
        .Load_Valid(Load_Valid), .Load_Ready(lr1),
        .Data_Input(Data_Input),
        .Serial_Output(so1), .Serial_Valid(sv1),
        .Serial_Ready(Serial_Ready), .Serial_Last(sl1),
        .Done(dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    bit    done_pend;

    int n_tests;
    int n_fail;
    bit s_so0, s_so1, s_sl0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_one(input string id, input logic lr, input logic sv,
                             input logic so, input logic sl, input logic dn,
                             input bit ev, input bit eb, input bit el);
        chk({id, ".load_ready"}, lr, !ev && !done_pend);
        chk({id, ".valid"}, sv, ev);
        if (ev) chk({id, ".bit"}, so, eb);
        chk({id, ".last"}, sl, ev && el);
        chk({id, ".done"}, dn, done_pend);
    endtask

    task automatic check_outputs();
        bit ev, b0, l0, b1, l1;
        ev = (q0.size() > 0);
        b0 = ev ? q0[0].b : 1'b0;
        l0 = ev ? q0[0].last : 1'b0;
        b1 = ev ? q1[0].b : 1'b0;
        l1 = ev ? q1[0].last : 1'b0;
        check_one("lsb", lr0, sv0, so0, sl0, dn0, ev, b0, l0);
        check_one("msb", lr1, sv1, so1, sl1, dn1, ev, b1, l1);
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q0.push_back('{d[i], !PAR && i == W - 1});
            q1.push_back('{d[W-1-i], !PAR && i == W - 1});
        end
        if (PAR) begin
            q0.push_back('{^d, 1'b1});
            q1.push_back('{^d, 1'b1});
        end
    endtask

    task automatic model_update(input bit lv, input bit sr, input logic [W-1:0] d);
        if (done_pend) begin
            done_pend = 1'b0;
        end else if (q0.size() > 0) begin
            if (sr) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                if (q0.size() == 0) done_pend = 1'b1;
            end
        end else if (lv) begin
            push_word(d);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        done_pend = 1'b0;
    endtask

    task automatic step(output bit done_seen);
        bit lv, sr;
        logic [W-1:0] d;
        @(negedge clk);
        check_outputs();
        done_seen = dn0;
        s_so0 = so0;
        s_so1 = so1;
        s_sl0 = sl0;
        lv = Load_Valid;
        sr = Serial_Ready;
        d  = Data_Input;
        @(posedge clk);
        if (rst_n) model_update(lv, sr, d);
        #1;
    endtask

    task automatic run_word(input logic [W-1:0] d, input int stall_at,
                            input int stall_len, output int done_k,
                            output bit f0, output bit f1, output bit pbit);
        bit ds;
        Data_Input   = d;
        Load_Valid   = 1'b1;
        Serial_Ready = 1'b1;
        step(ds);
        Load_Valid = 1'b0;
        done_k = -1;
        f0 = 1'b0;
        f1 = 1'b0;
        pbit = 1'b0;
        for (int k = 1; k <= 100 && done_k < 0; k++) begin
            Serial_Ready = !(k > stall_at && k <= stall_at + stall_len);
            step(ds);
            if (k == 1) begin
                f0 = s_so0;
                f1 = s_so1;
            end
            if (s_sl0) pbit = s_so0;
            if (ds) done_k = k;
        end
        if (done_k < 0) chk("done_timeout", 0, 1);
        Serial_Ready = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] data;
        bit           f_lsb;
        bit           f_msb;
        bit           par;
    } vec_t;

    initial begin
        vec_t tbl[7];
        bit   ds, f0, f1, pb;
        int   dk;

        n_tests = 0;
        n_fail  = 0;
        model_clear();
        rst_n        = 1'b0;
        Load_Valid   = 1'b0;
        Data_Input   = '0;
        Serial_Ready = 1'b1;

        tbl[0] = '{16'hA5C3, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{16'h8001, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'h00FF, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{16'h0001, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h7FFE, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{16'h0100, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) begin
            step(ds);
            chk("reset.out_lsb", so0, 1'b0);
            chk("reset.out_msb", so1, 1'b0);
        end
        rst_n = 1'b1;
        step(ds);

        foreach (tbl[i]) begin
            run_word(tbl[i].data, 0, 0, dk, f0, f1, pb);
            chk("tbl.done_cycle", dk, FRAME + 1);
            chk("tbl.first_lsb", f0, tbl[i].f_lsb);
            chk("tbl.first_msb", f1, tbl[i].f_msb);
            chk("tbl.last_beat", pb, PAR ? tbl[i].par : tbl[i].data[W-1]);
        end

        run_word(16'h00FF, 4, 3, dk, f0, f1, pb);
        chk("stall.done_cycle", dk, FRAME + 1 + 3);

        Data_Input = 16'hFFFF;
        Load_Valid = 1'b1;
        step(ds);
        Load_Valid = 1'b0;
        for (int k = 1; k <= 7; k++) step(ds);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.valid_lsb", sv0, 1'b0);
        chk("midreset.valid_msb", sv1, 1'b0);
        chk("midreset.done", dn0, 1'b0);
        chk("midreset.load_ready", lr0, 1'b1);
        model_clear();
        step(ds);
        step(ds);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(ds);
        run_word(16'h0001, 0, 0, dk, f0, f1, pb);
        chk("postreset.done_cycle", dk, FRAME + 1);
        chk("postreset.first_lsb", f0, 1'b1);

        for (int c = 0; c < 400; c++) begin
            Data_Input   = W'($urandom);
            Load_Valid   = 1'($urandom_range(0, 1));
            Serial_Ready = ($urandom_range(0, 3) != 0);
            step(ds);
        end
        Load_Valid   = 1'b0;
        Serial_Ready = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) step(ds);
        chk("drain.idle", lr0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
